// File: rtl/l0i_line_buffer_pkg.sv
// Shared types for the single-line L0 instruction buffer: memory message
// layouts for the 32-bit and 256-bit ports, type codes and controller states.
package l0i_line_buffer_pkg;

  localparam int unsigned LINE_NBITS  = 256;
  localparam int unsigned WORD_NBITS  = 32;
  localparam int unsigned LINE_WORDS  = LINE_NBITS / WORD_NBITS;
  localparam int unsigned TAG_LSB     = 5;
  localparam int unsigned TAG_NBITS   = 32 - TAG_LSB;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

  // Line refills use len=0 to mean a full line; narrow writes carry 4 bytes.
  localparam logic [4:0] LINE_LEN_FULL  = 5'd0;
  localparam logic [4:0] LINE_LEN_WORD  = 5'd4;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_32_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_32_t;

  typedef struct packed {
    logic [2:0]            typ;
    logic [7:0]            opaque;
    logic [31:0]           addr;
    logic [4:0]            len;
    logic [LINE_NBITS-1:0] data;
  } mem_req_256_t;

  typedef struct packed {
    logic [2:0]            typ;
    logic [7:0]            opaque;
    logic [1:0]            test;
    logic [4:0]            len;
    logic [LINE_NBITS-1:0] data;
  } mem_resp_256_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESP,
    ST_REFILL_REQ,
    ST_REFILL_WAIT,
    ST_WRITE_REQ,
    ST_WRITE_WAIT
  } state_e;

endpackage

// File: rtl/l0i_line_buffer_dpath.sv
// Datapath of the L0 line buffer: latched request, line storage, tag/valid,
// the 8:1 word select and formatting of both outgoing messages.
module l0i_line_buffer_dpath
  import l0i_line_buffer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  L0_disable_i,
  input  mem_req_32_t           req_msg_i,
  input  logic                  req_en_i,
  input  logic                  line_we_i,
  input  logic                  valid_clr_i,
  input  logic [LINE_NBITS-1:0] line_data_i,
  output logic                  req_hit_o,
  output mem_req_256_t          memreq_msg_o,
  output mem_resp_32_t          buffresp_msg_o
);

  mem_req_32_t           req_q;
  logic [LINE_NBITS-1:0] line_q;
  logic [TAG_NBITS-1:0]  tag_q;
  logic                  valid_q;
  logic                  valid_d;
  logic                  lat_is_write;
  logic [WORD_NBITS-1:0] line_words [LINE_WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_words
      assign line_words[gi] = line_q[gi*WORD_NBITS +: WORD_NBITS];
    end
  endgenerate

  // A completed refill wins over invalidation; both never occur together.
  always_comb begin
    valid_d = valid_q;
    if (line_we_i) begin
      valid_d = !L0_disable_i;
    end else if (valid_clr_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_q   <= '0;
      line_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (req_en_i) begin
        req_q <= req_msg_i;
      end
      if (line_we_i) begin
        line_q <= line_data_i;
        tag_q  <= req_q.addr[31:TAG_LSB];
      end
    end
  end

  // Tag check is done on the incoming request so a hit answers next cycle.
  assign req_hit_o    = valid_q && !L0_disable_i &&
                        (tag_q == req_msg_i.addr[31:TAG_LSB]);
  assign lat_is_write = (req_q.typ == MEM_TYPE_WRITE);

  always_comb begin
    memreq_msg_o        = '0;
    memreq_msg_o.opaque = req_q.opaque;
    if (lat_is_write) begin
      memreq_msg_o.typ                 = MEM_TYPE_WRITE;
      memreq_msg_o.addr                = req_q.addr;
      memreq_msg_o.len                 = LINE_LEN_WORD;
      memreq_msg_o.data[WORD_NBITS-1:0] = req_q.data;
    end else begin
      memreq_msg_o.typ  = MEM_TYPE_READ;
      memreq_msg_o.addr = {req_q.addr[31:TAG_LSB], {TAG_LSB{1'b0}}};
      memreq_msg_o.len  = LINE_LEN_FULL;
    end
  end

  always_comb begin
    buffresp_msg_o        = '0;
    buffresp_msg_o.typ    = req_q.typ;
    buffresp_msg_o.opaque = req_q.opaque;
    buffresp_msg_o.len    = req_q.len;
    buffresp_msg_o.data   = lat_is_write ? '0 : line_words[req_q.addr[4:2]];
  end

endmodule

// File: rtl/l0i_line_buffer.sv
// Single-line L0 instruction buffer: answers word reads from one cached
// 32-byte line, refills on a miss and forwards writes after invalidating.
module l0i_line_buffer
  import l0i_line_buffer_pkg::*;
#(
  parameter int unsigned p_line_nbits = 256,
  parameter int unsigned p_word_nbits = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      L0_disable,
  input  logic                      buffreq_val,
  output logic                      buffreq_rdy,
  input  logic [p_word_nbits+44:0]  buffreq_msg,
  output logic                      buffresp_val,
  input  logic                      buffresp_rdy,
  output logic [p_word_nbits+14:0]  buffresp_msg,
  output logic                      memreq_val,
  input  logic                      memreq_rdy,
  output logic [p_line_nbits+47:0]  memreq_msg,
  input  logic                      memresp_val,
  output logic                      memresp_rdy,
  input  logic [p_line_nbits+17:0]  memresp_msg
);

  state_e        state_q;
  state_e        state_d;
  mem_req_32_t   req_in;
  mem_resp_256_t mresp;
  mem_req_256_t  mreq;
  mem_resp_32_t  bresp;
  logic          req_hit;
  logic          req_is_write;
  logic          req_en;
  logic          line_we;
  logic          valid_clr;
  logic          unused_mresp_bits;

  assign req_in       = buffreq_msg;
  assign mresp        = memresp_msg;
  assign memreq_msg   = mreq;
  assign buffresp_msg = bresp;
  assign req_is_write = (req_in.typ == MEM_TYPE_WRITE);

  // The line response's header is deliberately ignored.
  assign unused_mresp_bits = ^{mresp.typ, mresp.opaque, mresp.test, mresp.len};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    buffreq_rdy  = 1'b0;
    buffresp_val = 1'b0;
    memreq_val   = 1'b0;
    memresp_rdy  = 1'b0;
    req_en       = 1'b0;
    line_we      = 1'b0;
    valid_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        buffreq_rdy = 1'b1;
        if (buffreq_val) begin
          req_en = 1'b1;
          if (req_is_write) begin
            valid_clr = 1'b1;
            state_d   = ST_WRITE_REQ;
          end else if (req_hit) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_REFILL_REQ;
          end
        end
      end
      ST_REFILL_REQ: begin
        memreq_val = 1'b1;
        if (memreq_rdy) begin
          state_d = ST_REFILL_WAIT;
        end
      end
      ST_REFILL_WAIT: begin
        memresp_rdy = 1'b1;
        if (memresp_val) begin
          line_we = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_WRITE_REQ: begin
        memreq_val = 1'b1;
        if (memreq_rdy) begin
          state_d = ST_WRITE_WAIT;
        end
      end
      ST_WRITE_WAIT: begin
        memresp_rdy = 1'b1;
        if (memresp_val) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        buffresp_val = 1'b1;
        if (buffresp_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshakes stay quiet while reset is held, so nothing is accepted.
    if (!reset) begin
      buffreq_rdy  = 1'b0;
      buffresp_val = 1'b0;
      memreq_val   = 1'b0;
      memresp_rdy  = 1'b0;
      req_en       = 1'b0;
      line_we      = 1'b0;
      valid_clr    = 1'b0;
    end
  end

  l0i_line_buffer_dpath u_dpath (
    .clk            (clk),
    .reset          (reset),
    .L0_disable_i   (L0_disable),
    .req_msg_i      (req_in),
    .req_en_i       (req_en),
    .line_we_i      (line_we),
    .valid_clr_i    (valid_clr),
    .line_data_i    (mresp.data),
    .req_hit_o      (req_hit),
    .memreq_msg_o   (mreq),
    .buffresp_msg_o (bresp)
  );

endmodule

// File: doc/l0i_line_buffer.md
# l0i_line_buffer

Single-line L0 instruction buffer between the processor's 32-bit instruction-memory port and the 256-bit line-wide instruction-memory port. It holds one 32-byte line. Word reads that hit the line are answered locally. Misses issue one 256-bit line refill. Writes invalidate the line and are forwarded as narrow writes. The buffer sits inside the processor tile, directly downstream of the processor fetch stage and upstream of the memory system.

## Interface
Parameters
- p_line_nbits, 256: memory-side line width; the design is fixed to 8 words.
- p_word_nbits, 32: processor-side data width.

Ports
- clk  in  1: clock.
- reset  in  1: synchronous, active-low; the block is reset on a rising clk edge where reset==0.
- L0_disable  in  1: force every read to miss; the line is never marked valid.
- buffreq_val/rdy  in/out  1/1: processor request handshake.
- buffreq_msg  in  77: {type[76:74], opaque[73:66], addr[65:34], len[33:32], data[31:0]}.
- buffresp_val/rdy  out/in  1/1: processor response handshake.
- buffresp_msg  out  47: {type[46:44], opaque[43:36], test[35:34], len[33:32], data[31:0]}.
- memreq_val/rdy  out/in  1/1: line request handshake.
- memreq_msg  out  304: {type[303:301], opaque[300:293], addr[292:261], len[260:256], data[255:0]}.
- memresp_val/rdy  in/out  1/1: line response handshake.
- memresp_msg  in  274: {type[273:271], opaque[270:263], test[262:261], len[260:256], data[255:0]}.

## Operation
- A transfer occurs on any clk edge where val and rdy are both high.
- One request is outstanding at a time.
- FSM states: IDLE, RESP, REFILL_REQ, REFILL_WAIT, WRITE_REQ, WRITE_WAIT. Reset state is IDLE.
- IDLE
  - buffreq_rdy=1. On transfer, latch the message into an input register.
  - Read hit (line_valid and addr[31:5]==tag and !L0_disable) -> RESP.
  - Read miss -> REFILL_REQ.
  - Write (type=1) -> clear line_valid, then WRITE_REQ.
- REFILL_REQ
  - memreq_val=1 with type=READ, opaque=latched opaque, addr={addr[31:5],5'b0}, len=0 (full line), data=0.
  - On transfer -> REFILL_WAIT.
- REFILL_WAIT
  - memresp_rdy=1. On transfer, capture the line and set tag=addr[31:5].
  - line_valid is set to !L0_disable.
  - Next state -> RESP.
- WRITE_REQ
  - memreq_val=1 with type=WRITE, addr=latched addr, len=4, data={224'b0, word}.
  - On transfer -> WRITE_WAIT.
- WRITE_WAIT
  - memresp_rdy=1. On transfer -> RESP, returning data=0.
- RESP
  - buffresp_val=1.
  - Message: type and opaque from the latched request, test=0, len=latched len.
  - Read data = line[32*addr[4:2] +: 32].
  - Message is held stable until buffresp_rdy. On transfer -> IDLE.
- rdy/val outputs not listed for a state are 0.
- A line response's opaque and type are not checked.
- L0_disable changing mid-transaction affects only the next tag check and the next valid-bit set.

## Timing
- Reset values: all val outputs 0, buffreq_rdy 0, memresp_rdy 0, line_valid 0, state IDLE. buffreq_rdy rises in the first cycle after reset deasserts.
- Hit: request accepted at edge N -> buffresp_val high during cycle N+1 -> zero-stall round trip of 2 cycles. Throughput is one request per 2 cycles.
- Miss: memreq_val high during cycle N+1. The memory response is accepted at edge M. buffresp_val is high during cycle M+1.
- Back-pressure: any number of stall cycles is legal on buffresp_rdy or memreq_rdy. Outputs do not change while stalled.
- Reset mid-refill: state returns to IDLE and line_valid clears. A later stray memresp is not consumed, because memresp_rdy=0 in IDLE.
- Boundary conditions:
  - addr[1:0] is ignored.
  - A hit on word 7 selects data[255:224].
  - A refill of the same tag overwrites the whole line.

## Structure
- Shared package holds:
  - mem_msg field typedefs and widths for the 32-bit and 256-bit request and response formats;
  - type constants READ=0, WRITE=1;
  - the FSM state enum.
- Split into a control unit (FSM, handshakes) and a datapath (input register, line register, tag, valid bit, 8:1 word mux). The datapath is named l0i_line_buffer_dpath.

## Test plan
- Reset, then read 0x1004 with opaque 0x3.
  - Required: one memreq to addr 0x1000 with len 0.
  - Return a line whose word k=0x100+k. Response data must be 0x101 with opaque 0x3.
- Follow with a read of 0x101C.
  - Required: no memreq; response 0x107 exactly 2 cycles after the request transfer.
- Read 0x2000 after line 0x1000 is valid.
  - Required: refill to 0x2000.
  - A subsequent read of 0x1000 must miss again.
- Assert L0_disable and issue two reads of 0x1000.
  - Required: two refills; the line is never marked valid.
- Write 0xDEADBEEF to 0x1008.
  - Required: memreq type=1, addr 0x1008, len 4, data low word 0xDEADBEEF.
  - Response type=1 with data 0. The next read of 0x1000 misses.
- Hold buffresp_rdy=0 for 5 cycles on a hit, then drop reset to 0 during REFILL_WAIT.
  - Required: response held stable during the stall.
  - After the reset, the first read misses.
